// File: rtl/pe_stream_ctrl.sv
// Sequences one PE through a row job: config load, filter/ifmap/ipsum streaming
// from the local buffer through a 2-entry read FIFO, and opsum write-back.
module pe_stream_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg,
    input  logic [ADDR_W-1:0]      filter_base,
    input  logic [ADDR_W-1:0]      ifmap_base,
    input  logic [ADDR_W-1:0]      ipsum_base,
    input  logic [ADDR_W-1:0]      opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic [DATA_BITS-1:0]   mem_rd_data,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [DATA_BITS-1:0]   mem_wr_data,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic [DATA_BITS-1:0]   pe_data,
    output logic                   pe_filter_valid,
    output logic                   pe_ifmap_valid,
    output logic                   pe_ipsum_valid,
    input  logic                   pe_filter_ready,
    input  logic                   pe_ifmap_ready,
    input  logic                   pe_ipsum_ready,
    input  logic [DATA_BITS-1:0]   pe_opsum,
    input  logic                   pe_opsum_valid,
    output logic                   pe_opsum_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_FILTER = 3'd2,
        ST_IFMAP  = 3'd3,
        ST_IPSUM  = 3'd4,
        ST_OPSUM  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                 state_r, state_s;
    logic [CONFIG_SIZE-1:0] cfg_r;
    logic [ADDR_W-1:0]      filter_base_r, ifmap_base_r, ipsum_base_r, opsum_base_r;
    logic [ADDR_W-1:0]      flt_ptr_r, ifm_ptr_r, ips_ptr_r, ops_ptr_r;
    logic [5:0]             col_cnt_r, issued_r, popped_r;
    logic [2:0]             opsum_cnt_r;
    logic                   inflight_r;
    logic [DATA_BITS-1:0]   fifo_r [2];
    logic                   fifo_wr_idx_r, fifo_rd_idx_r;
    logic [1:0]             fifo_cnt_r;

    logic [2:0]        p_s, q_s, rs_s, n_psum_s;
    logic [1:0]        u_s;
    logic [5:0]        n_flt_s, n_col_s, phase_len_s;
    logic              streaming_s, stream_ready_s, head_valid_s;
    logic              accept_s, issue_s, pop_s, last_pop_s, wr_s, last_wr_s, last_col_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // Derived job geometry; every field is stored as value-1.
    assign p_s      = {1'b0, cfg_r[8:7]} + 3'd1;
    assign q_s      = {1'b0, cfg_r[1:0]} + 3'd1;
    assign rs_s     = {1'b0, cfg_r[11:10]} + 3'd1;
    assign u_s      = {1'b0, cfg_r[9]} + 2'd1;
    assign n_flt_s  = {3'b000, p_s} * {3'b000, rs_s};
    assign n_psum_s = cfg_r[12] ? q_s : p_s;
    assign n_col_s  = {1'b0, cfg_r[6:2]} + 6'd1;

    assign accept_s     = (state_r == ST_IDLE) && start;
    assign issue_s      = streaming_s && (issued_r < phase_len_s) &&
                          (({1'b0, fifo_cnt_r} + {2'b00, inflight_r}) < 3'd2);
    assign head_valid_s = streaming_s && (fifo_cnt_r != 2'd0);
    assign pop_s        = head_valid_s && stream_ready_s;
    assign last_pop_s   = pop_s && (popped_r == (phase_len_s - 6'd1));
    assign wr_s         = (state_r == ST_OPSUM) && pe_opsum_valid;
    assign last_wr_s    = wr_s && (opsum_cnt_r == (n_psum_s - 3'd1));
    assign last_col_s   = (col_cnt_r == (n_col_s - 6'd1));

    // Phase decode: active stream, its length, read address and PE readiness.
    always_comb begin
        streaming_s    = 1'b0;
        phase_len_s    = 6'd0;
        rd_addr_s      = '0;
        stream_ready_s = 1'b0;
        case (state_r)
            ST_FILTER: begin
                streaming_s    = 1'b1;
                phase_len_s    = n_flt_s;
                rd_addr_s      = filter_base_r + flt_ptr_r;
                stream_ready_s = pe_filter_ready;
            end
            ST_IFMAP: begin
                streaming_s    = 1'b1;
                phase_len_s    = (col_cnt_r == 6'd0) ? {3'b000, rs_s} : {4'b0000, u_s};
                rd_addr_s      = ifmap_base_r + ifm_ptr_r;
                stream_ready_s = pe_ifmap_ready;
            end
            ST_IPSUM: begin
                streaming_s    = 1'b1;
                phase_len_s    = {3'b000, n_psum_s};
                rd_addr_s      = ipsum_base_r + ips_ptr_r;
                stream_ready_s = pe_ipsum_ready;
            end
            default: begin
                streaming_s = 1'b0;
            end
        endcase
    end

    // Next-state logic; phases only advance on their final pop or write.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = start ? ST_CFG : ST_IDLE;
            ST_CFG:    state_s = ST_FILTER;
            ST_FILTER: state_s = last_pop_s ? ST_IFMAP : ST_FILTER;
            ST_IFMAP:  state_s = last_pop_s ? ST_IPSUM : ST_IFMAP;
            ST_IPSUM:  state_s = last_pop_s ? ST_OPSUM : ST_IPSUM;
            ST_OPSUM: begin
                if (last_wr_s) begin
                    state_s = last_col_s ? ST_DONE : ST_IFMAP;
                end else begin
                    state_s = ST_OPSUM;
                end
            end
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Address/data outputs are zeroed when their strobe is low.
    assign busy            = (state_r != ST_IDLE);
    assign done            = (state_r == ST_DONE);
    assign pe_en           = (state_r == ST_CFG);
    assign pe_config       = cfg_r;
    assign mem_rd_en       = issue_s;
    assign mem_rd_addr     = issue_s ? rd_addr_s : '0;
    assign pe_data         = head_valid_s ? fifo_r[fifo_rd_idx_r] : '0;
    assign pe_filter_valid = head_valid_s && (state_r == ST_FILTER);
    assign pe_ifmap_valid  = head_valid_s && (state_r == ST_IFMAP);
    assign pe_ipsum_valid  = head_valid_s && (state_r == ST_IPSUM);
    assign pe_opsum_ready  = (state_r == ST_OPSUM);
    assign mem_wr_en       = wr_s;
    assign mem_wr_addr     = wr_s ? (opsum_base_r + ops_ptr_r) : '0;
    assign mem_wr_data     = wr_s ? pe_opsum : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job latch: config and region bases change only when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_r         <= '0;
            filter_base_r <= '0;
            ifmap_base_r  <= '0;
            ipsum_base_r  <= '0;
            opsum_base_r  <= '0;
        end else if (accept_s) begin
            cfg_r         <= cfg;
            filter_base_r <= filter_base;
            ifmap_base_r  <= ifmap_base;
            ipsum_base_r  <= ipsum_base;
            opsum_base_r  <= opsum_base;
        end
    end

    // Region pointers run continuously over the job; phase counters restart per phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_ptr_r   <= '0;
            ifm_ptr_r   <= '0;
            ips_ptr_r   <= '0;
            ops_ptr_r   <= '0;
            col_cnt_r   <= 6'd0;
            issued_r    <= 6'd0;
            popped_r    <= 6'd0;
            opsum_cnt_r <= 3'd0;
        end else if (accept_s) begin
            flt_ptr_r   <= '0;
            ifm_ptr_r   <= '0;
            ips_ptr_r   <= '0;
            ops_ptr_r   <= '0;
            col_cnt_r   <= 6'd0;
            issued_r    <= 6'd0;
            popped_r    <= 6'd0;
            opsum_cnt_r <= 3'd0;
        end else begin
            if (issue_s) begin
                case (state_r)
                    ST_FILTER: flt_ptr_r <= flt_ptr_r + ADDR_W'(1);
                    ST_IFMAP:  ifm_ptr_r <= ifm_ptr_r + ADDR_W'(1);
                    ST_IPSUM:  ips_ptr_r <= ips_ptr_r + ADDR_W'(1);
                    default:   flt_ptr_r <= flt_ptr_r;
                endcase
            end
            if (last_pop_s) begin
                issued_r <= 6'd0;
                popped_r <= 6'd0;
            end else begin
                issued_r <= issued_r + {5'd0, issue_s};
                popped_r <= popped_r + {5'd0, pop_s};
            end
            if (wr_s) begin
                ops_ptr_r   <= ops_ptr_r + ADDR_W'(1);
                opsum_cnt_r <= last_wr_s ? 3'd0 : (opsum_cnt_r + 3'd1);
            end
            if (last_wr_s) begin
                col_cnt_r <= col_cnt_r + 6'd1;
            end
        end
    end

    // Read-data FIFO: data lands one cycle after the request, head pops on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_r[0]     <= '0;
            fifo_r[1]     <= '0;
            fifo_wr_idx_r <= 1'b0;
            fifo_rd_idx_r <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            inflight_r    <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (inflight_r) begin
                fifo_r[fifo_wr_idx_r] <= mem_rd_data;
                fifo_wr_idx_r         <= ~fifo_wr_idx_r;
            end
            if (pop_s) begin
                fifo_rd_idx_r <= ~fifo_rd_idx_r;
            end
            case ({inflight_r, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Scoreboard bench for pe_stream_ctrl: a buffer model, a randomized PE model and
// a monitor that compares every read, stream handshake and write with the reference.
module tb_pe_stream_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CS = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CS-1:0] cfg;
    logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
    logic          busy, done, mem_rd_en, mem_wr_en, pe_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data, pe_data, pe_opsum;
    logic [CS-1:0] pe_config;
    logic          pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid;
    logic          pe_filter_ready, pe_ifmap_ready, pe_ipsum_ready;
    logic          pe_opsum_valid, pe_opsum_ready;

    pe_stream_ctrl #(.ADDR_W(AW), .DATA_BITS(DW), .CONFIG_SIZE(CS)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg(cfg),
        .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .pe_en(pe_en), .pe_config(pe_config), .pe_data(pe_data),
        .pe_filter_valid(pe_filter_valid), .pe_ifmap_valid(pe_ifmap_valid),
        .pe_ipsum_valid(pe_ipsum_valid),
        .pe_filter_ready(pe_filter_ready), .pe_ifmap_ready(pe_ifmap_ready),
        .pe_ipsum_ready(pe_ipsum_ready),
        .pe_opsum(pe_opsum), .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] strm; logic [AW-1:0] addr; } rd_exp_t;
    typedef struct packed { logic [1:0] strm; logic [DW-1:0] data; } xf_exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;

    logic [DW-1:0] mem [4096];
    rd_exp_t       rd_q[$];
    xf_exp_t       xf_q[$];
    wr_exp_t       wr_q[$];
    logic [DW-1:0] ops_vals[$];
    int            ops_idx = 0;
    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;
    int            pe_en_cnt = 0;
    int            rdy_mode = 0;
    bit            saw_ipsum = 1'b0;
    bit            rd_pend = 1'b0;
    logic [AW-1:0] rd_pend_addr = '0;
    logic [CS-1:0] exp_cfg = '0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rd(input logic [1:0] s, input logic [AW-1:0] a);
        rd_exp_t r;
        xf_exp_t x;
        r.strm = s; r.addr = a;
        x.strm = s; x.data = mem[a];
        rd_q.push_back(r);
        xf_q.push_back(x);
    endtask

    // Reference model: the full ordered job from the config fields with plain loops.
    task automatic build_expect(input logic [CS-1:0] c, input logic [AW-1:0] fb, input logic [AW-1:0] ib,
                                input logic [AW-1:0] pb, input logic [AW-1:0] ob);
        int p, q, rs, u, ncol, np, ifp, ipp, k;
        wr_exp_t w;
        logic [DW-1:0] v;
        p = int'(c[8:7]) + 1; q = int'(c[1:0]) + 1; rs = int'(c[11:10]) + 1;
        u = int'(c[9]) + 1; ncol = int'(c[6:2]) + 1;
        np = c[12] ? q : p;
        rd_q.delete(); xf_q.delete(); wr_q.delete(); ops_vals.delete();
        ops_idx = 0; done_cnt = 0; pe_en_cnt = 0; saw_ipsum = 1'b0; exp_cfg = c;
        for (int i = 0; i < p * rs; i++) push_rd(2'd0, fb + AW'(i));
        ifp = 0; ipp = 0; k = 0;
        for (int col = 0; col < ncol; col++) begin
            for (int j = 0; j < ((col == 0) ? rs : u); j++) begin push_rd(2'd1, ib + AW'(ifp)); ifp++; end
            for (int j = 0; j < np; j++) begin push_rd(2'd2, pb + AW'(ipp)); ipp++; end
            for (int j = 0; j < np; j++) begin
                v = $urandom;
                ops_vals.push_back(v);
                w.addr = ob + AW'(k); w.data = v;
                wr_q.push_back(w);
                k++;
            end
        end
    endtask

    // Buffer and PE model: drives all DUT response inputs on the falling edge.
    initial begin
        int cyc;
        cyc = 0;
        mem_rd_data = '0; pe_opsum = '0; pe_opsum_valid = 1'b0;
        pe_filter_ready = 1'b0; pe_ifmap_ready = 1'b0; pe_ipsum_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rd_data = rd_pend ? mem[rd_pend_addr] : DW'($urandom);
            case (rdy_mode)
                0: begin pe_filter_ready = 1'b1; pe_ifmap_ready = 1'b1; pe_ipsum_ready = 1'b1; end
                1: begin
                    pe_filter_ready = 1'($urandom_range(0, 1));
                    pe_ifmap_ready  = 1'($urandom_range(0, 1));
                    pe_ipsum_ready  = 1'($urandom_range(0, 1));
                end
                default: begin pe_filter_ready = cyc[0]; pe_ifmap_ready = 1'b1; pe_ipsum_ready = 1'b1; end
            endcase
            if (ops_idx < ops_vals.size()) begin
                pe_opsum       = ops_vals[ops_idx];
                pe_opsum_valid = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                pe_opsum       = DW'($urandom);
                pe_opsum_valid = 1'b0;
            end
        end
    end

    // Monitor: samples mid-cycle and scores every DUT action against the queues.
    initial begin
        int occ;
        bit prev_stall;
        logic [2:0] valids, readies, hs, prev_valids;
        logic [DW-1:0] prev_data;
        logic [1:0] strm;
        rd_exp_t re;
        xf_exp_t xe;
        wr_exp_t we;
        occ = 0; prev_stall = 1'b0; prev_valids = 3'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            #3;
            valids  = {pe_ipsum_valid, pe_ifmap_valid, pe_filter_valid};
            readies = {pe_ipsum_ready, pe_ifmap_ready, pe_filter_ready};
            if (rst) begin
                check(({busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, pe_en,
                        pe_config, pe_data, valids, pe_opsum_ready} == '0), "reset_outputs_zero",
                      {63'd0, busy | done | mem_rd_en | mem_wr_en | pe_en | (|valids) | pe_opsum_ready}, 64'd0);
                occ = 0; prev_stall = 1'b0; rd_pend = 1'b0;
            end else begin
                if (valids != 3'b0) check($countones(valids) <= 1, "one_valid", {61'd0, valids}, 64'd1);
                if (prev_stall) check((valids == prev_valids) && (pe_data == prev_data), "stall_hold", pe_data, prev_data);
                if (busy) check(pe_config == exp_cfg, "pe_config", pe_config, exp_cfg);
                if (pe_en) begin
                    pe_en_cnt++;
                    check(pe_config == exp_cfg, "cfg_load", pe_config, exp_cfg);
                end
                rd_pend = mem_rd_en;
                rd_pend_addr = mem_rd_addr;
                if (mem_rd_en) begin
                    check(!pe_opsum_ready && !mem_wr_en, "rd_during_opsum", {63'd0, pe_opsum_ready}, 64'd0);
                    check(occ < 2, "fifo_occupancy", occ, 64'd1);
                    check(rd_q.size() > 0, "read_expected", mem_rd_addr, 64'd0);
                    if (rd_q.size() > 0) begin
                        re = rd_q.pop_front();
                        check(mem_rd_addr == re.addr, "rd_addr", mem_rd_addr, re.addr);
                        if (xf_q.size() > 0) check(xf_q[0].strm == re.strm, "rd_phase", re.strm, xf_q[0].strm);
                    end
                end
                hs = valids & readies;
                if (hs != 3'b0) begin
                    strm = hs[0] ? 2'd0 : (hs[1] ? 2'd1 : 2'd2);
                    check(xf_q.size() > 0, "xfer_expected", pe_data, 64'd0);
                    if (xf_q.size() > 0) begin
                        xe = xf_q.pop_front();
                        check(strm == xe.strm, "xfer_stream", strm, xe.strm);
                        check(pe_data == xe.data, "xfer_data", pe_data, xe.data);
                    end
                    occ--;
                end
                if (mem_rd_en) occ++;
                if (pe_ipsum_valid) saw_ipsum = 1'b1;
                if (mem_wr_en || (pe_opsum_valid && pe_opsum_ready)) begin
                    check(mem_wr_en && pe_opsum_valid && pe_opsum_ready, "wr_handshake",
                          {62'd0, mem_wr_en, pe_opsum_ready}, 64'd3);
                    check(wr_q.size() > 0, "write_expected", mem_wr_addr, 64'd0);
                    if (mem_wr_en && (wr_q.size() > 0)) begin
                        we = wr_q.pop_front();
                        check(mem_wr_addr == we.addr, "wr_addr", mem_wr_addr, we.addr);
                        check(mem_wr_data == we.data, "wr_data", mem_wr_data, we.data);
                    end
                    if (pe_opsum_valid && pe_opsum_ready) ops_idx++;
                end
                if (done) done_cnt++;
                prev_stall  = (valids != 3'b0) && (hs == 3'b0);
                prev_valids = valids;
                prev_data   = pe_data;
            end
        end
    end

    task automatic launch(input logic [CS-1:0] c, input logic [AW-1:0] fb, input logic [AW-1:0] ib,
                          input logic [AW-1:0] pb, input logic [AW-1:0] ob, input int mode, input bit hold);
        build_expect(c, fb, ib, pb, ob);
        rdy_mode = mode;
        @(negedge clk);
        start = 1'b1; cfg = c; filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
        @(negedge clk);
        check(busy == 1'b1, "busy_after_start", {63'd0, busy}, 64'd1);
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                cfg = CS'($urandom); filter_base = AW'($urandom); ifmap_base = AW'($urandom);
                ipsum_base = AW'($urandom); opsum_base = AW'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic run_job(input logic [CS-1:0] c, input logic [AW-1:0] fb, input logic [AW-1:0] ib,
                           input logic [AW-1:0] pb, input logic [AW-1:0] ob, input int mode, input bit hold);
        launch(c, fb, ib, pb, ob, mode, hold);
        for (int i = 0; (i < 6000) && (done_cnt == 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(done_cnt == 1, "done_pulses", done_cnt, 64'd1);
        check(pe_en_cnt == 1, "pe_en_pulses", pe_en_cnt, 64'd1);
        check(busy == 1'b0, "busy_after_done", {63'd0, busy}, 64'd0);
        check(rd_q.size() == 0, "reads_left", rd_q.size(), 64'd0);
        check(xf_q.size() == 0, "xfers_left", xf_q.size(), 64'd0);
        check(wr_q.size() == 0, "writes_left", wr_q.size(), 64'd0);
    endtask

    initial begin
        logic [CS-1:0] c;
        rst = 1'b0; start = 1'b0; cfg = '0;
        filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // cfg layout: {dw, rs-1, U-1, p-1, F, q-1}
        run_job({1'b0, 2'd2, 1'b0, 2'd0, 5'd0, 2'd0}, 12'h100, 12'h200, 12'h300, 12'h400, 0, 1'b0);
        run_job({1'b0, 2'd2, 1'b0, 2'd1, 5'd2, 2'd0}, 12'h110, 12'h210, 12'h310, 12'h410, 0, 1'b1);
        run_job({1'b0, 2'd2, 1'b1, 2'd0, 5'd1, 2'd0}, 12'h120, 12'h220, 12'h320, 12'h420, 0, 1'b0);
        run_job({1'b1, 2'd0, 1'b0, 2'd0, 5'd0, 2'd2}, 12'h130, 12'h230, 12'h330, 12'h430, 1, 1'b0);
        run_job({1'b0, 2'd3, 1'b0, 2'd3, 5'd1, 2'd0}, 12'h140, 12'h240, 12'h340, 12'h440, 2, 1'b0);
        run_job({1'b0, 2'd1, 1'b1, 2'd1, 5'd3, 2'd1}, 12'hFFC, 12'hFFE, 12'hFFF, 12'hFFD, 1, 1'b0);
        // Abort mid-IPSUM with start still held, then a clean job.
        launch({1'b0, 2'd2, 1'b0, 2'd1, 5'd2, 2'd0}, 12'h500, 12'h600, 12'h700, 12'h800, 0, 1'b1);
        start = 1'b1;
        for (int i = 0; (i < 2000) && !saw_ipsum; i++) @(negedge clk);
        check(saw_ipsum, "reach_ipsum", {63'd0, saw_ipsum}, 64'd1);
        start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd_q.delete(); xf_q.delete(); wr_q.delete(); ops_vals.delete(); ops_idx = 0; done_cnt = 0;
        repeat (5) @(negedge clk);
        check(done_cnt == 0, "no_done_after_abort", done_cnt, 64'd0);
        run_job({1'b0, 2'd2, 1'b0, 2'd1, 5'd2, 2'd0}, 12'h500, 12'h600, 12'h700, 12'h800, 0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            c = CS'($urandom);
            c[6:2] = 5'($urandom_range(0, 5));
            run_job(c, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
